// File: rtl/moesi_snoop_ctrl.sv
// MOESI snoop controller: queues bus snoops, looks up the indexed set,
// writes back the new line state, requests data supply, and responds.
module moesi_snoop_ctrl #(
    parameter int ADDR_W          = 64,
    parameter int OFFSET_W        = 6,
    parameter int INDEX_W         = 6,
    parameter int NUM_WAYS        = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int E_SUPPLIES_DATA = 1,
    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W,
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      snp_valid,
    output logic                      snp_ready,
    input  logic [1:0]                snp_type,
    input  logic [ADDR_W-1:0]         snp_addr,
    output logic                      lk_req,
    output logic [INDEX_W-1:0]        lk_set,
    input  logic [NUM_WAYS*TAG_W-1:0] lk_tag,
    input  logic [NUM_WAYS*3-1:0]     lk_state,
    output logic                      st_wr_en,
    output logic [INDEX_W-1:0]        st_wr_set,
    output logic [WAY_W-1:0]          st_wr_way,
    output logic [2:0]                st_wr_state,
    output logic                      data_req,
    output logic [WAY_W-1:0]          data_way,
    input  logic                      data_ack,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_hit,
    output logic                      resp_shared,
    output logic                      resp_dirty,
    output logic                      resp_supply,
    output logic                      err_multi_hit,
    output logic [31:0]               stat_snoops,
    output logic [31:0]               stat_hits
);

    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_M = 3'b000;
    localparam logic [2:0] ST_O = 3'b001;
    localparam logic [2:0] ST_E = 3'b010;
    localparam logic [2:0] ST_S = 3'b011;
    localparam logic [2:0] ST_I = 3'b100;

    localparam logic [1:0] T_NOP = 2'b00;
    localparam logic [1:0] T_RD  = 2'b01;
    localparam logic [1:0] T_WR  = 2'b10;
    localparam logic [1:0] T_UP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        UPDATE,
        DATA,
        RESP
    } fsm_t;

    fsm_t state;

    logic [1:0]        f_type [FIFO_DEPTH];
    logic [LINE_W-1:0] f_line [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [1:0]        head_type;
    logic [LINE_W-1:0] head_line;

    logic [1:0]         wk_type;
    logic [INDEX_W-1:0] wk_set;
    logic [TAG_W-1:0]   wk_tag;

    logic             hit;
    logic             multi;
    logic [WAY_W-1:0] sel;
    logic [2:0]       cur;
    logic [2:0]       nxt;
    logic             sup;
    logic             e_sup;
    logic             unused_offset;

    assign unused_offset = ^snp_addr[OFFSET_W-1:0];
    assign e_sup = (E_SUPPLIES_DATA != 0);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign snp_ready = !full;
    assign push = snp_valid && !full;
    assign pop  = (state == IDLE) && !empty;

    assign head_type = f_type[rd_ptr[PTR_W-1:0]];
    assign head_line = f_line[rd_ptr[PTR_W-1:0]];

    // Read strobe issues while the head is popped so tags return in LOOKUP.
    assign lk_req = pop && (head_type != T_NOP);
    assign lk_set = lk_req ? head_line[INDEX_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            f_type[wr_ptr[PTR_W-1:0]] <= snp_type;
            f_line[wr_ptr[PTR_W-1:0]] <= snp_addr[ADDR_W-1:OFFSET_W];
        end
    end

    always_comb begin
        hit   = 1'b0;
        multi = 1'b0;
        sel   = '0;
        cur   = ST_I;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (lk_tag[w*TAG_W +: TAG_W] == wk_tag &&
                lk_state[w*3 +: 3] != ST_I) begin
                if (hit) begin
                    multi = 1'b1;
                end else begin
                    hit = 1'b1;
                    sel = WAY_W'(w);
                    cur = lk_state[w*3 +: 3];
                end
            end
        end
        nxt = cur;
        sup = 1'b0;
        if (hit) begin
            unique case (wk_type)
                T_RD: begin
                    case (cur)
                        ST_M: begin
                            nxt = ST_O;
                            sup = 1'b1;
                        end
                        ST_O: sup = 1'b1;
                        ST_E: begin
                            nxt = ST_S;
                            sup = e_sup;
                        end
                        default: ;
                    endcase
                end
                T_WR: begin
                    nxt = ST_I;
                    sup = (cur == ST_M) || (cur == ST_O) ||
                          (cur == ST_E && e_sup);
                end
                T_UP: nxt = ST_I;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wk_type       <= T_NOP;
            wk_set        <= '0;
            wk_tag        <= '0;
            st_wr_en      <= 1'b0;
            st_wr_set     <= '0;
            st_wr_way     <= '0;
            st_wr_state   <= '0;
            data_req      <= 1'b0;
            data_way      <= '0;
            resp_valid    <= 1'b0;
            resp_hit      <= 1'b0;
            resp_shared   <= 1'b0;
            resp_dirty    <= 1'b0;
            resp_supply   <= 1'b0;
            err_multi_hit <= 1'b0;
            stat_snoops   <= '0;
            stat_hits     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            st_wr_en      <= 1'b0;
            err_multi_hit <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        wk_type <= head_type;
                        wk_set  <= head_line[INDEX_W-1:0];
                        wk_tag  <= head_line[LINE_W-1:INDEX_W];
                        if (head_type == T_NOP) begin
                            resp_valid  <= 1'b1;
                            resp_hit    <= 1'b0;
                            resp_shared <= 1'b0;
                            resp_dirty  <= 1'b0;
                            resp_supply <= 1'b0;
                            state       <= RESP;
                        end else begin
                            state <= LOOKUP;
                        end
                    end
                end
                LOOKUP: begin
                    st_wr_en      <= hit && (nxt != cur);
                    st_wr_set     <= wk_set;
                    st_wr_way     <= sel;
                    st_wr_state   <= nxt;
                    err_multi_hit <= multi;
                    resp_hit      <= hit;
                    resp_shared   <= hit && (wk_type == T_RD);
                    resp_dirty    <= hit && (cur == ST_M || cur == ST_O);
                    resp_supply   <= sup;
                    state         <= UPDATE;
                end
                UPDATE: begin
                    if (resp_supply) begin
                        data_req <= 1'b1;
                        data_way <= st_wr_way;
                        state    <= DATA;
                    end else begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                DATA: begin
                    if (data_ack) begin
                        data_req   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid  <= 1'b0;
                        resp_hit    <= 1'b0;
                        resp_shared <= 1'b0;
                        resp_dirty  <= 1'b0;
                        resp_supply <= 1'b0;
                        stat_snoops <= stat_snoops + 32'd1;
                        if (resp_hit) stat_hits <= stat_hits + 32'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
